// File: rtl/game_countdown_timer.sv
// BCD mm:ss countdown timer driven by an external millisecond tick.
// Loads a start time, runs or pauses on command, and pulses time_up on reaching 00:00.
module game_countdown_timer #(
    parameter int unsigned MS_PER_SEC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       one_ms_pulse,
    input  logic       load,
    input  logic [3:0] load_min_tens,
    input  logic [3:0] load_min_ones,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    input  logic       start,
    input  logic       stop,
    output logic       tick_enable,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       time_up
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    typedef struct packed {
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
    } bcd_time_t;

    localparam logic [15:0] MS_LAST = 16'(MS_PER_SEC - 1);

    state_t     state;
    bcd_time_t  cur;
    bcd_time_t  dec;
    bcd_time_t  ld;
    logic [15:0] ms_count;
    logic       cur_zero;
    logic       dec_zero;

    function automatic logic [3:0] clamp(input logic [3:0] d, input logic [3:0] max_v);
        return (d > max_v) ? max_v : d;
    endfunction

    // NOTE: combinational blocks use blocking assignments and give every output a
    // default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        ld.mt = clamp(load_min_tens, 4'd9);
        ld.mo = clamp(load_min_ones, 4'd9);
        ld.st = clamp(load_sec_tens, 4'd5);
        ld.so = clamp(load_sec_ones, 4'd9);

        dec = cur;
        if (cur.so != 4'd0) begin
            dec.so = cur.so - 4'd1;
        end else begin
            dec.so = 4'd9;
            if (cur.st != 4'd0) begin
                dec.st = cur.st - 4'd1;
            end else begin
                dec.st = 4'd5;
                if (cur.mo != 4'd0) begin
                    dec.mo = cur.mo - 4'd1;
                end else begin
                    dec.mo = 4'd9;
                    dec.mt = cur.mt - 4'd1;
                end
            end
        end

        cur_zero = (cur == '0);
        dec_zero = (dec == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        time_up <= 1'b0;
        if (rst) begin
            state       <= IDLE;
            cur         <= '0;
            ms_count    <= '0;
            tick_enable <= 1'b0;
            running     <= 1'b0;
        end else if (load) begin
            state       <= IDLE;
            cur         <= ld;
            ms_count    <= '0;
            tick_enable <= 1'b0;
            running     <= 1'b0;
        end else if (start && (state == IDLE || state == PAUSE)) begin
            if (cur_zero) begin
                state       <= EXPIRED;
                time_up     <= 1'b1;
                tick_enable <= 1'b0;
                running     <= 1'b0;
            end else begin
                state       <= RUN;
                tick_enable <= 1'b1;
                running     <= 1'b1;
            end
        end else if (stop && state == RUN) begin
            state       <= PAUSE;
            tick_enable <= 1'b0;
            running     <= 1'b0;
        end else if (state == RUN && one_ms_pulse) begin
            if (ms_count == MS_LAST) begin
                ms_count <= '0;
                if (!cur_zero) begin
                    cur <= dec;
                    if (dec_zero) begin
                        state       <= EXPIRED;
                        time_up     <= 1'b1;
                        tick_enable <= 1'b0;
                        running     <= 1'b0;
                    end
                end
            end else begin
                ms_count <= ms_count + 16'd1;
            end
        end
    end

    assign min_tens = cur.mt;
    assign min_ones = cur.mo;
    assign sec_tens = cur.st;
    assign sec_ones = cur.so;

endmodule

// File: tb/tb_game_countdown_timer.sv
// Scoreboarded random + directed bench for game_countdown_timer, with a
// seconds-based reference model and a per-cycle output monitor.
module tb_game_countdown_timer;

    localparam int MS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       one_ms_pulse = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_min_tens = '0, load_min_ones = '0, load_sec_tens = '0, load_sec_ones = '0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       tick_enable, running, time_up;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;

    game_countdown_timer #(.MS_PER_SEC(MS)) dut (
        .clk(clk), .rst(rst), .one_ms_pulse(one_ms_pulse), .load(load),
        .load_min_tens(load_min_tens), .load_min_ones(load_min_ones),
        .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
        .start(start), .stop(stop), .tick_enable(tick_enable),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .time_up(time_up)
    );

    always #5 clk = ~clk;

    // Reference model: remaining time as plain seconds, phase as a small integer.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXP = 3;
    int m_secs = 0;
    int m_ms = 0;
    int m_state = M_IDLE;
    bit m_tu = 0;

    typedef struct packed {
        logic       te;
        logic       run;
        logic       tu;
        logic [15:0] digits;
    } obs_t;

    obs_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_cycle = 0;

    function automatic logic [15:0] to_bcd(input int secs);
        int mins, s;
        mins = secs / 60;
        s    = secs % 60;
        return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic int clampi(input logic [3:0] d, input int mx);
        return (int'(d) > mx) ? mx : int'(d);
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got te=%0b run=%0b tu=%0b time=%h, expected te=%0b run=%0b tu=%0b time=%h",
                     name, got.te, got.run, got.tu, got.digits, want.te, want.run, want.tu, want.digits);
        end
    endtask

    // Monitor: one output snapshot per clock, compared away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                obs_t got, want;
                want = exp_q.pop_front();
                got  = '{te: tick_enable, run: running, tu: time_up,
                         digits: {min_tens, min_ones, sec_tens, sec_ones}};
                check($sformatf("cycle%0d", n_cycle), got, want);
            end
        end
    end

    // One clock of stimulus: drive, advance model, wait for the edge, queue expectation.
    task automatic cycle(input bit r, input bit p, input bit l, input bit s, input bit t,
                         input logic [15:0] d);
        obs_t e;
        rst = r; one_ms_pulse = p; load = l; start = s; stop = t;
        {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = d;

        m_tu = 0;
        if (r) begin
            m_secs = 0; m_ms = 0; m_state = M_IDLE;
        end else if (l) begin
            m_secs = (clampi(d[15:12], 9) * 10 + clampi(d[11:8], 9)) * 60
                   + clampi(d[7:4], 5) * 10 + clampi(d[3:0], 9);
            m_ms = 0; m_state = M_IDLE;
        end else if (s && (m_state == M_IDLE || m_state == M_PAUSE)) begin
            if (m_secs == 0) begin
                m_state = M_EXP; m_tu = 1;
            end else begin
                m_state = M_RUN;
            end
        end else if (t && m_state == M_RUN) begin
            m_state = M_PAUSE;
        end else if (p && m_state == M_RUN) begin
            m_ms = (m_ms + 1) % MS;
            if (m_ms == 0 && m_secs > 0) begin
                m_secs--;
                if (m_secs == 0) begin
                    m_state = M_EXP; m_tu = 1;
                end
            end
        end

        e = '{te: (m_state == M_RUN), run: (m_state == M_RUN), tu: m_tu, digits: to_bcd(m_secs)};
        @(posedge clk);
        n_cycle++;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic do_load(input logic [15:0] d);
        cycle(0, 0, 1, 0, 0, d);
    endtask

    task automatic do_start();
        cycle(0, 0, 0, 1, 0, 16'h0);
    endtask

    task automatic do_stop();
        cycle(0, 0, 0, 0, 1, 16'h0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(0, 1, 0, 0, 0, 16'h0);
            cycle(0, 0, 0, 0, 0, 16'h0);
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, 0, 16'h0);
        idle(1);

        // Reset mid-run at 12:34.
        do_load(16'h1234); do_start(); ticks(2);
        cycle(1, 0, 0, 0, 0, 16'h0);
        idle(1);

        // 01:00 -> 00:59 -> 00:58.
        do_load(16'h0100); do_start(); ticks(4); ticks(4);

        // Borrow chain 10:00 -> 09:59.
        do_load(16'h1000); do_start(); ticks(4);

        // Expiry from 00:01, then ticks and start are ignored.
        do_load(16'h0001); do_start(); ticks(4); ticks(3); do_start(); idle(2);

        // Pause and resume; the tick coincident with stop is dropped.
        do_load(16'h0005); do_start(); ticks(2);
        cycle(0, 1, 0, 0, 1, 16'h0);
        ticks(5); do_start(); ticks(2); do_stop(); idle(1);

        // Clamping of illegal digits.
        do_load(16'hFA7C); idle(1);

        // Start at 00:00 expires immediately; load wins over start.
        do_load(16'h0000); do_start(); idle(2);
        cycle(0, 0, 1, 1, 0, 16'h0003); idle(2);

        // Load wins over a coincident pulse in RUN.
        do_start(); ticks(1);
        cycle(0, 1, 1, 0, 0, 16'h0002); do_start(); ticks(4);

        // Randomized command mix; short load values keep expiry reachable.
        for (int i = 0; i < 3000; i++) begin
            bit r, p, l, s, t;
            logic [15:0] d;
            r = ($urandom_range(0, 199) == 0);
            l = ($urandom_range(0, 39) == 0);
            s = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) d = 16'($urandom_range(0, 3));
            else d = 16'($urandom);
            cycle(r, p, l, s, t, d);
        end

        idle(2);
        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
